// File: rtl/pipe_hazard_scoreboard_if.sv
// Decode-side bundle for the hazard scoreboard: instruction fields, operand
// sources and the resolved stall/forwarding outputs.
interface pipe_hazard_scoreboard_if #(
   parameter int DATA_W = 16,
   parameter int REG_AW = 4,
   parameter int DEPTH  = 3,
   parameter int CNT_W  = 16
);
   logic                    id_valid;
   logic [REG_AW-1:0]       id_rs;
   logic [REG_AW-1:0]       id_rt;
   logic                    id_use_rs;
   logic                    id_use_rt;
   logic                    id_wr_en;
   logic [REG_AW-1:0]       id_dest;
   logic                    id_is_load;
   logic [DATA_W-1:0]       rf_rs_data;
   logic [DATA_W-1:0]       rf_rt_data;
   logic [DEPTH*DATA_W-1:0] stage_res;
   logic                    flush;
   logic                    ext_hold;
   logic                    stall;
   logic [2:0]              fwd_sel_rs;
   logic [2:0]              fwd_sel_rt;
   logic [DATA_W-1:0]       op_a;
   logic [DATA_W-1:0]       op_b;
   logic [CNT_W-1:0]        stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_dest,
             id_is_load, rf_rs_data, rf_rt_data, stage_res, flush, ext_hold,
      input  stall, fwd_sel_rs, fwd_sel_rt, op_a, op_b, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_dest,
             id_is_load, rf_rs_data, rf_rt_data, stage_res, flush, ext_hold,
      output stall, fwd_sel_rs, fwd_sel_rt, op_a, op_b, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// Shift-register scoreboard of in-flight instructions (slot 1 = EX .. DEPTH = WB)
// driving the decode stall and per-operand forwarding selection.
module pipe_hazard_scoreboard #(
   parameter int DATA_W     = 16,
   parameter int REG_AW     = 4,
   parameter int DEPTH      = 3,
   parameter int LOAD_READY = 2,
   parameter int ZERO_REG   = 1,
   parameter int CNT_W      = 16
) (
   input logic                     clk,
   input logic                     rst,
   pipe_hazard_scoreboard_if.slave hz
);
   logic [DEPTH:1]     valid_q, valid_d;
   logic [DEPTH:1]     wr_en_q, wr_en_d;
   logic [DEPTH:1]     is_load_q, is_load_d;
   logic [REG_AW-1:0]  dest_q [DEPTH:1];
   logic [REG_AW-1:0]  dest_d [DEPTH:1];
   logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

   logic [DATA_W-1:0]  slot_res [DEPTH:1];
   logic [2:0]         sel_rs, sel_rt;
   logic               wait_rs, wait_rt;
   logic [DATA_W-1:0]  op_a, op_b;
   logic               rs_zero, rt_zero;
   logic               stall;

   for (genvar g = 1; g <= DEPTH; g++) begin : g_res
      assign slot_res[g] = hz.stage_res[(g-1)*DATA_W +: DATA_W];
   end

   assign rs_zero = (ZERO_REG != 0) && (hz.id_rs == '0);
   assign rt_zero = (ZERO_REG != 0) && (hz.id_rt == '0);

   // Walk oldest to youngest so the youngest matching slot ends up selected.
   always_comb begin
      sel_rs  = '0;
      sel_rt  = '0;
      wait_rs = 1'b0;
      wait_rt = 1'b0;
      op_a    = hz.rf_rs_data;
      op_b    = hz.rf_rt_data;
      for (int k = DEPTH; k >= 1; k--) begin
         if (hz.id_use_rs && !rs_zero && valid_q[k] && wr_en_q[k] && dest_q[k] == hz.id_rs) begin
            sel_rs  = 3'(k);
            wait_rs = is_load_q[k] && (k < LOAD_READY);
            op_a    = slot_res[k];
         end
         if (hz.id_use_rt && !rt_zero && valid_q[k] && wr_en_q[k] && dest_q[k] == hz.id_rt) begin
            sel_rt  = 3'(k);
            wait_rt = is_load_q[k] && (k < LOAD_READY);
            op_b    = slot_res[k];
         end
      end
      stall = hz.id_valid && !hz.flush && (wait_rs || wait_rt);
   end

   always_comb begin
      valid_d     = valid_q;
      wr_en_d     = wr_en_q;
      is_load_d   = is_load_q;
      dest_d      = dest_q;
      stall_cnt_d = stall_cnt_q;
      if (!hz.ext_hold) begin
         for (int k = DEPTH; k >= 2; k--) begin
            valid_d[k]   = valid_q[k-1];
            wr_en_d[k]   = wr_en_q[k-1];
            is_load_d[k] = is_load_q[k-1];
            dest_d[k]    = dest_q[k-1];
         end
         valid_d[1]   = hz.id_valid && !stall && !hz.flush;
         wr_en_d[1]   = hz.id_wr_en;
         is_load_d[1] = hz.id_is_load;
         dest_d[1]    = hz.id_dest;
         if (stall && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q     <= '0;
         wr_en_q     <= '0;
         is_load_q   <= '0;
         for (int k = 1; k <= DEPTH; k++) begin
            dest_q[k] <= '0;
         end
         stall_cnt_q <= '0;
      end else begin
         valid_q     <= valid_d;
         wr_en_q     <= wr_en_d;
         is_load_q   <= is_load_d;
         dest_q      <= dest_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign hz.stall      = stall;
   assign hz.fwd_sel_rs = sel_rs;
   assign hz.fwd_sel_rt = sel_rt;
   assign hz.op_a       = op_a;
   assign hz.op_b       = op_b;
   assign hz.stall_cnt  = stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// Bench for pipe_hazard_scoreboard: directed pipeline scenarios plus random
// traffic against an instruction-history model; a CNT_W=2 copy checks saturation.
module tb_pipe_hazard_scoreboard;
   localparam int DW  = 16;
   localparam int RW  = 4;
   localparam int DEP = 3;
   localparam int LR  = 2;
   localparam int ZR  = 1;

   logic clk;
   logic rst;
   int   n_pass;
   int   n_total;

   pipe_hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(RW), .DEPTH(DEP), .CNT_W(16)) hz ();
   pipe_hazard_scoreboard_if #(.DATA_W(DW), .REG_AW(RW), .DEPTH(DEP), .CNT_W(2))  hz2 ();

   pipe_hazard_scoreboard #(.DATA_W(DW), .REG_AW(RW), .DEPTH(DEP), .LOAD_READY(LR),
                            .ZERO_REG(ZR), .CNT_W(16)) u_dut (.clk(clk), .rst(rst), .hz(hz));
   pipe_hazard_scoreboard #(.DATA_W(DW), .REG_AW(RW), .DEPTH(DEP), .LOAD_READY(LR),
                            .ZERO_REG(ZR), .CNT_W(2)) u_dut2 (.clk(clk), .rst(rst), .hz(hz2));

   assign hz2.id_valid   = hz.id_valid;
   assign hz2.id_rs      = hz.id_rs;
   assign hz2.id_rt      = hz.id_rt;
   assign hz2.id_use_rs  = hz.id_use_rs;
   assign hz2.id_use_rt  = hz.id_use_rt;
   assign hz2.id_wr_en   = hz.id_wr_en;
   assign hz2.id_dest    = hz.id_dest;
   assign hz2.id_is_load = hz.id_is_load;
   assign hz2.rf_rs_data = hz.rf_rs_data;
   assign hz2.rf_rt_data = hz.rf_rt_data;
   assign hz2.stage_res  = hz.stage_res;
   assign hz2.flush      = hz.flush;
   assign hz2.ext_hold   = hz.ext_hold;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: history of issued instructions, index = cycles since issue.
   typedef struct {
      bit v;
      bit w;
      bit ld;
      int dest;
   } ins_t;

   ins_t    m_hist [1:DEP];
   int      m_cnt16;
   int      m_cnt2;
   bit      e_stall;
   int      e_sel_rs;
   int      e_sel_rt;
   logic [DW-1:0] e_op_a;
   logic [DW-1:0] e_op_b;

   function automatic void m_lookup(input int s, input bit use_s, output int sel, output bit not_ready);
      sel = 0;
      not_ready = 1'b0;
      if (!use_s || (ZR != 0 && s == 0)) return;
      for (int k = 1; k <= DEP; k++) begin
         if (m_hist[k].v && m_hist[k].w && m_hist[k].dest == s) begin
            sel = k;
            not_ready = m_hist[k].ld && (k < LR);
            return;
         end
      end
   endfunction

   function automatic void m_eval();
      bit nr_rs, nr_rt;
      m_lookup(int'(hz.id_rs), hz.id_use_rs, e_sel_rs, nr_rs);
      m_lookup(int'(hz.id_rt), hz.id_use_rt, e_sel_rt, nr_rt);
      e_stall = hz.id_valid && !hz.flush && (nr_rs || nr_rt);
      e_op_a  = (e_sel_rs != 0) ? hz.stage_res[(e_sel_rs-1)*DW +: DW] : hz.rf_rs_data;
      e_op_b  = (e_sel_rt != 0) ? hz.stage_res[(e_sel_rt-1)*DW +: DW] : hz.rf_rt_data;
   endfunction

   always @(posedge clk) begin
      m_eval();
      if (rst) begin
         for (int k = 1; k <= DEP; k++) m_hist[k] = '{v: 1'b0, w: 1'b0, ld: 1'b0, dest: 0};
         m_cnt16 = 0;
         m_cnt2  = 0;
      end else if (!hz.ext_hold) begin
         for (int k = DEP; k >= 2; k--) m_hist[k] = m_hist[k-1];
         m_hist[1] = '{v: hz.id_valid && !e_stall && !hz.flush, w: hz.id_wr_en,
                       ld: hz.id_is_load, dest: int'(hz.id_dest)};
         if (e_stall) begin
            if (m_cnt16 < 65535) m_cnt16++;
            if (m_cnt2 < 3) m_cnt2++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic idle();
      hz.id_valid   = 1'b0;
      hz.id_rs      = '0;
      hz.id_rt      = '0;
      hz.id_use_rs  = 1'b0;
      hz.id_use_rt  = 1'b0;
      hz.id_wr_en   = 1'b0;
      hz.id_dest    = '0;
      hz.id_is_load = 1'b0;
      hz.rf_rs_data = DW'($urandom);
      hz.rf_rt_data = DW'($urandom);
      hz.stage_res  = {DW'($urandom), DW'($urandom), DW'($urandom)};
      hz.flush      = 1'b0;
      hz.ext_hold   = 1'b0;
   endtask

   task automatic set_instr(input bit wr, input bit ld, input int dest);
      hz.id_valid   = 1'b1;
      hz.id_wr_en   = wr;
      hz.id_is_load = ld;
      hz.id_dest    = RW'(dest);
      hz.id_use_rs  = 1'b0;
      hz.id_use_rt  = 1'b0;
   endtask

   task automatic set_read(input bit ur, input int rs, input bit ut, input int rt);
      hz.id_use_rs = ur;
      hz.id_rs     = RW'(rs);
      hz.id_use_rt = ut;
      hz.id_rt     = RW'(rt);
   endtask

   task automatic set_slot(input int k, input logic [DW-1:0] val);
      hz.stage_res[(k-1)*DW +: DW] = val;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      set_instr(1'b0, 1'b0, 0);
      set_read(1'b1, 1, 1'b1, 2);
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd0 || hz.fwd_sel_rt !== 3'd0
          || hz.op_a !== hz.rf_rs_data || hz.op_b !== hz.rf_rt_data)
         $display("FAIL reset_outputs: stall=%0b sel=%0d/%0d op=%h/%h want 0 0/0 %h/%h",
                  hz.stall, hz.fwd_sel_rs, hz.fwd_sel_rt, hz.op_a, hz.op_b, hz.rf_rs_data, hz.rf_rt_data);
      else n_pass++;
      n_total++;
      if (hz.stall_cnt !== 16'd0 || hz2.stall_cnt !== 2'd0)
         $display("FAIL reset_cnt: cnt=%0d cnt2=%0d want 0 0", hz.stall_cnt, hz2.stall_cnt);
      else n_pass++;
   endtask

   task automatic test_alu_forward();
      do_reset();
      set_instr(1'b1, 1'b0, 3);
      step();
      set_instr(1'b1, 1'b0, 8);
      set_read(1'b1, 3, 1'b1, 7);
      set_slot(1, 16'h1234);
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd1 || hz.op_a !== 16'h1234
          || hz.fwd_sel_rt !== 3'd0 || hz.op_b !== hz.rf_rt_data)
         $display("FAIL alu_forward: stall=%0b sel=%0d/%0d op_a=%h op_b=%h want 0 1/0 1234 %h",
                  hz.stall, hz.fwd_sel_rs, hz.fwd_sel_rt, hz.op_a, hz.op_b, hz.rf_rt_data);
      else n_pass++;
      step();
   endtask

   task automatic test_load_use();
      do_reset();
      set_instr(1'b1, 1'b1, 5);
      step();
      set_instr(1'b1, 1'b0, 9);
      set_read(1'b0, 0, 1'b1, 5);
      set_slot(2, 16'hBEEF);
      mid();
      n_total++;
      if (hz.stall !== 1'b1 || hz.stall_cnt !== 16'd0)
         $display("FAIL load_use_stall: stall=%0b cnt=%0d want 1 0", hz.stall, hz.stall_cnt);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rt !== 3'd2 || hz.op_b !== 16'hBEEF || hz.stall_cnt !== 16'd1)
         $display("FAIL load_use_release: stall=%0b sel=%0d op_b=%h cnt=%0d want 0 2 beef 1",
                  hz.stall, hz.fwd_sel_rt, hz.op_b, hz.stall_cnt);
      else n_pass++;
      // One independent instruction between load and use hides the latency.
      do_reset();
      set_instr(1'b1, 1'b1, 5);
      step();
      set_instr(1'b1, 1'b0, 6);
      step();
      set_instr(1'b0, 1'b0, 0);
      set_read(1'b1, 5, 1'b0, 0);
      set_slot(2, 16'hCAFE);
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd2 || hz.op_a !== 16'hCAFE || hz.stall_cnt !== 16'd0)
         $display("FAIL load_gap: stall=%0b sel=%0d op_a=%h cnt=%0d want 0 2 cafe 0",
                  hz.stall, hz.fwd_sel_rs, hz.op_a, hz.stall_cnt);
      else n_pass++;
   endtask

   task automatic test_zero_reg();
      do_reset();
      set_instr(1'b1, 1'b1, 0);
      step();
      set_instr(1'b1, 1'b0, 0);
      step();
      set_instr(1'b0, 1'b0, 0);
      set_read(1'b1, 0, 1'b1, 0);
      hz.rf_rs_data = '0;
      hz.rf_rt_data = '0;
      set_slot(1, 16'h5555);
      set_slot(2, 16'hAAAA);
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd0 || hz.fwd_sel_rt !== 3'd0
          || hz.op_a !== 16'h0 || hz.op_b !== 16'h0)
         $display("FAIL zero_reg: stall=%0b sel=%0d/%0d op=%h/%h want 0 0/0 0000/0000",
                  hz.stall, hz.fwd_sel_rs, hz.fwd_sel_rt, hz.op_a, hz.op_b);
      else n_pass++;
   endtask

   task automatic test_youngest_wins();
      do_reset();
      set_instr(1'b1, 1'b0, 4);
      step();
      set_instr(1'b1, 1'b0, 4);
      step();
      set_instr(1'b0, 1'b0, 0);
      set_read(1'b0, 0, 1'b1, 4);
      set_slot(1, 16'h0002);
      set_slot(2, 16'h0001);
      mid();
      n_total++;
      if (hz.fwd_sel_rt !== 3'd1 || hz.op_b !== 16'h0002)
         $display("FAIL youngest_wins: sel=%0d op_b=%h want 1 0002", hz.fwd_sel_rt, hz.op_b);
      else n_pass++;
      do_reset();
      set_instr(1'b1, 1'b0, 4);
      step();
      idle();
      step();
      step();
      set_read(1'b1, 4, 1'b0, 0);
      set_slot(3, 16'h7777);
      mid();
      n_total++;
      if (hz.fwd_sel_rs !== 3'(DEP) || hz.op_a !== 16'h7777)
         $display("FAIL oldest_slot: sel=%0d op_a=%h want %0d 7777", hz.fwd_sel_rs, hz.op_a, DEP);
      else n_pass++;
      step();
      mid();
      n_total++;
      if (hz.fwd_sel_rs !== 3'd0 || hz.op_a !== hz.rf_rs_data)
         $display("FAIL retired: sel=%0d op_a=%h want 0 %h", hz.fwd_sel_rs, hz.op_a, hz.rf_rs_data);
      else n_pass++;
   endtask

   task automatic test_ext_hold();
      do_reset();
      set_instr(1'b1, 1'b1, 6);
      step();
      set_instr(1'b1, 1'b0, 10);
      set_read(1'b1, 6, 1'b0, 0);
      hz.ext_hold = 1'b1;
      for (int i = 0; i < 3; i++) begin
         mid();
         n_total++;
         if (hz.stall !== 1'b1 || hz.stall_cnt !== 16'd0)
            $display("FAIL hold_frozen[%0d]: stall=%0b cnt=%0d want 1 0", i, hz.stall, hz.stall_cnt);
         else n_pass++;
         step();
      end
      hz.ext_hold = 1'b0;
      mid();
      n_total++;
      if (hz.stall !== 1'b1 || hz.stall_cnt !== 16'd0)
         $display("FAIL hold_release: stall=%0b cnt=%0d want 1 0", hz.stall, hz.stall_cnt);
      else n_pass++;
      step();
      set_slot(2, 16'h6006);
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd2 || hz.op_a !== 16'h6006 || hz.stall_cnt !== 16'd1)
         $display("FAIL hold_after: stall=%0b sel=%0d op_a=%h cnt=%0d want 0 2 6006 1",
                  hz.stall, hz.fwd_sel_rs, hz.op_a, hz.stall_cnt);
      else n_pass++;
   endtask

   task automatic test_flush();
      do_reset();
      set_instr(1'b1, 1'b1, 7);
      step();
      set_instr(1'b1, 1'b0, 7);
      set_read(1'b1, 7, 1'b0, 0);
      hz.flush = 1'b1;
      mid();
      n_total++;
      if (hz.stall !== 1'b0)
         $display("FAIL flush_no_stall: stall=%0b want 0", hz.stall);
      else n_pass++;
      step();
      hz.flush = 1'b0;
      set_instr(1'b0, 1'b0, 0);
      set_read(1'b1, 7, 1'b0, 0);
      set_slot(1, 16'h1111);
      set_slot(2, 16'h2222);
      mid();
      n_total++;
      if (hz.fwd_sel_rs !== 3'd2 || hz.op_a !== 16'h2222 || hz.stall_cnt !== 16'd0)
         $display("FAIL flush_bubble: sel=%0d op_a=%h cnt=%0d want 2 2222 0",
                  hz.fwd_sel_rs, hz.op_a, hz.stall_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid_stall();
      do_reset();
      set_instr(1'b1, 1'b1, 2);
      step();
      set_instr(1'b1, 1'b0, 11);
      set_read(1'b1, 2, 1'b0, 0);
      step();
      set_instr(1'b1, 1'b1, 2);
      step();
      set_instr(1'b1, 1'b0, 11);
      set_read(1'b1, 2, 1'b0, 0);
      mid();
      n_total++;
      if (hz.stall !== 1'b1 || hz.stall_cnt !== 16'd1)
         $display("FAIL pre_reset_stall: stall=%0b cnt=%0d want 1 1", hz.stall, hz.stall_cnt);
      else n_pass++;
      rst = 1'b1;
      step();
      rst = 1'b0;
      mid();
      n_total++;
      if (hz.stall !== 1'b0 || hz.fwd_sel_rs !== 3'd0 || hz.op_a !== hz.rf_rs_data || hz.stall_cnt !== 16'd0)
         $display("FAIL reset_mid_stall: stall=%0b sel=%0d op_a=%h cnt=%0d want 0 0 %h 0",
                  hz.stall, hz.fwd_sel_rs, hz.op_a, hz.stall_cnt, hz.rf_rs_data);
      else n_pass++;
   endtask

   task automatic test_cnt_saturate();
      do_reset();
      for (int i = 0; i < 5; i++) begin
         set_instr(1'b1, 1'b1, 1);
         step();
         set_instr(1'b0, 1'b0, 0);
         hz.id_valid = 1'b1;
         set_read(1'b1, 1, 1'b0, 0);
         step();
         step();
         if (i == 1) begin
            n_total++;
            if (hz2.stall_cnt !== 2'd2)
               $display("FAIL cnt_two: cnt2=%0d want 2", hz2.stall_cnt);
            else n_pass++;
         end
      end
      mid();
      n_total++;
      if (hz2.stall_cnt !== 2'd3 || hz.stall_cnt !== 16'd5)
         $display("FAIL cnt_saturate: cnt2=%0d cnt=%0d want 3 5", hz2.stall_cnt, hz.stall_cnt);
      else n_pass++;
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         rst           = ($urandom_range(0, 63) == 0);
         hz.id_valid   = ($urandom_range(0, 7) != 0);
         hz.id_rs      = RW'($urandom_range(0, 3));
         hz.id_rt      = RW'($urandom_range(0, 3));
         hz.id_use_rs  = $urandom_range(0, 1);
         hz.id_use_rt  = $urandom_range(0, 1);
         hz.id_wr_en   = ($urandom_range(0, 3) != 0);
         hz.id_dest    = RW'($urandom_range(0, 3));
         hz.id_is_load = ($urandom_range(0, 2) == 0);
         hz.rf_rs_data = DW'($urandom);
         hz.rf_rt_data = DW'($urandom);
         hz.stage_res  = {DW'($urandom), DW'($urandom), DW'($urandom)};
         hz.flush      = ($urandom_range(0, 9) == 0);
         hz.ext_hold   = ($urandom_range(0, 9) == 0);
         mid();
         m_eval();
         n_total++;
         if (hz.stall !== e_stall)
            $display("FAIL rnd_stall[%0d]: stall=%0b want %0b", c, hz.stall, e_stall);
         else n_pass++;
         if (!e_stall) begin
            n_total++;
            if (hz.fwd_sel_rs !== 3'(e_sel_rs) || hz.fwd_sel_rt !== 3'(e_sel_rt)
                || hz.op_a !== e_op_a || hz.op_b !== e_op_b)
               $display("FAIL rnd_fwd[%0d]: sel=%0d/%0d op=%h/%h want %0d/%0d %h/%h", c,
                        hz.fwd_sel_rs, hz.fwd_sel_rt, hz.op_a, hz.op_b, e_sel_rs, e_sel_rt, e_op_a, e_op_b);
            else n_pass++;
         end
         n_total++;
         if (hz.stall_cnt !== 16'(m_cnt16) || hz2.stall_cnt !== 2'(m_cnt2))
            $display("FAIL rnd_cnt[%0d]: cnt=%0d cnt2=%0d want %0d %0d", c,
                     hz.stall_cnt, hz2.stall_cnt, m_cnt16, m_cnt2);
         else n_pass++;
         step();
      end
      rst = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_pass  = 0;
      n_total = 0;
      rst     = 1'b1;
      idle();
      step();
      test_reset();
      test_alu_forward();
      test_load_use();
      test_zero_reg();
      test_youngest_wins();
      test_ext_hold();
      test_flush();
      test_reset_mid_stall();
      test_cnt_saturate();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
